// File: rtl/puc_pkg.sv
// Shared definitions for the partial-tag uncache predictor: defaults, entry layout,
// FSM encoding and the entry update rule shared by the write path and the read bypass.
package puc_pkg;

  localparam int PUC_IDX_W      = 5;
  localparam int PUC_TAG_W      = 4;
  localparam int PUC_CNT_W      = 2;
  localparam int PUC_RD_PORTS   = 2;

  // Widest tag/counter the shared entry type can carry; instances zero-extend into it.
  localparam int PUC_TAG_MAX_W  = 16;
  localparam int PUC_CNT_MAX_W  = 8;

  localparam int PUC_CTR_LSB    = 0;
  localparam int PUC_TAG_LSB    = PUC_CTR_LSB + PUC_CNT_MAX_W;
  localparam int PUC_VALID_BIT  = PUC_TAG_LSB + PUC_TAG_MAX_W;
  localparam int PUC_ENTRY_W    = PUC_VALID_BIT + 1;

  typedef enum logic {
    PUC_IDLE  = 1'b0,
    PUC_CLEAR = 1'b1
  } puc_state_e;

  typedef struct packed {
    logic                     valid;
    logic [PUC_TAG_MAX_W-1:0] tag;
    logic [PUC_CNT_MAX_W-1:0] ctr;
  } puc_entry_t;

  function automatic logic [PUC_CNT_MAX_W-1:0] puc_ctr_ones(input int cnt_w);
    logic [PUC_CNT_MAX_W-1:0] ones;
    ones = '0;
    for (int i = 0; i < PUC_CNT_MAX_W; i++) begin
      ones[i] = (i < cnt_w);
    end
    return ones;
  endfunction

  // A hit keeps the tag and takes the saturated counter; a miss allocates a strong counter.
  function automatic puc_entry_t puc_entry_next(
    input puc_entry_t               cur,
    input logic [PUC_TAG_MAX_W-1:0] tag,
    input logic                     uc,
    input logic [PUC_CNT_MAX_W-1:0] sat_ctr,
    input logic [PUC_CNT_MAX_W-1:0] ctr_ones
  );
    puc_entry_t nxt;
    nxt.valid = 1'b1;
    nxt.tag   = tag;
    if (cur.valid && (cur.tag == tag)) begin
      nxt.ctr = sat_ctr;
    end else begin
      nxt.ctr = uc ? ctr_ones : '0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/predictor_puc_tagged_if.sv
// Request/response bundle of the uncache predictor: read ports, training port, flush and busy.
interface predictor_puc_tagged_if import puc_pkg::*; #(
  parameter int IDX_W    = PUC_IDX_W,
  parameter int TAG_W    = PUC_TAG_W,
  parameter int RD_PORTS = PUC_RD_PORTS
);
  localparam int ADDR_W = IDX_W + TAG_W;

  logic [RD_PORTS*ADDR_W-1:0] rd_addr_i;
  logic [RD_PORTS-1:0]        rd_uc_o;
  logic [RD_PORTS-1:0]        rd_hit_o;
  logic                       upd_valid_i;
  logic [ADDR_W-1:0]          upd_addr_i;
  logic                       upd_uc_i;
  logic                       flush_i;
  logic                       busy_o;

  modport master (
    output rd_addr_i, upd_valid_i, upd_addr_i, upd_uc_i, flush_i,
    input  rd_uc_o, rd_hit_o, busy_o
  );

  modport slave (
    input  rd_addr_i, upd_valid_i, upd_addr_i, upd_uc_i, flush_i,
    output rd_uc_o, rd_hit_o, busy_o
  );

endinterface

// File: rtl/puc_sat_ctr.sv
// Saturating up/down next-value logic for one hysteresis counter; CNT_W=1 degenerates to set/clear.
module puc_sat_ctr #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != {CNT_W{1'b1}}) begin
        ctr_o = ctr_i + CNT_W'(1);
      end
    end else begin
      if (ctr_i != {CNT_W{1'b0}}) begin
        ctr_o = ctr_i - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/predictor_puc_tagged.sv
// Partial-tag uncache-attribute predictor: combinational read ports with update bypass,
// one training port and a one-entry-per-cycle clear walk after reset or flush.
module predictor_puc_tagged import puc_pkg::*; #(
  parameter int IDX_W      = PUC_IDX_W,
  parameter int TAG_W      = PUC_TAG_W,
  parameter int CNT_W      = PUC_CNT_W,
  parameter int RD_PORTS   = PUC_RD_PORTS,
  parameter bit DEFAULT_UC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  predictor_puc_tagged_if.slave bus
);

  localparam int ADDR_W = IDX_W + TAG_W;
  localparam int DEPTH  = 2 ** IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [CNT_W-1:0] ctr_q [DEPTH];

  puc_state_e       state_q;
  puc_state_e       state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             busy;
  logic             clear_en;
  logic             upd_accept;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [CNT_W-1:0] cur_ctr;
  logic [CNT_W-1:0] sat_ctr;
  puc_entry_t       cur_ent;
  puc_entry_t       wr_ent;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [CNT_W-1:0] wr_ctr;
  logic             unused_wr;

  logic [RD_PORTS-1:0] rd_hit;
  logic [RD_PORTS-1:0] rd_uc;

  assign upd_idx = bus.upd_addr_i[IDX_W-1:0];
  assign upd_tag = bus.upd_addr_i[ADDR_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PUC_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Flush outranks training; a flush during the walk restarts it from entry 0.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clear_en   = 1'b0;
    upd_accept = 1'b0;
    busy       = 1'b0;
    case (state_q)
      PUC_IDLE: begin
        if (bus.flush_i) begin
          state_d = PUC_CLEAR;
          ptr_d   = '0;
        end else begin
          upd_accept = bus.upd_valid_i && rst_n;
        end
      end
      PUC_CLEAR: begin
        busy     = 1'b1;
        clear_en = 1'b1;
        if (bus.flush_i) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == {IDX_W{1'b1}}) begin
            state_d = PUC_IDLE;
          end
        end
      end
      default: begin
        state_d = PUC_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign cur_ctr = ctr_q[upd_idx];

  puc_sat_ctr #(
    .CNT_W (CNT_W)
  ) u_sat_ctr (
    .ctr_i (cur_ctr),
    .up_i  (bus.upd_uc_i),
    .ctr_o (sat_ctr)
  );

  always_comb begin
    cur_ent       = '0;
    cur_ent.valid = valid_q[upd_idx];
    cur_ent.tag   = PUC_TAG_MAX_W'(tag_q[upd_idx]);
    cur_ent.ctr   = PUC_CNT_MAX_W'(cur_ctr);
    wr_ent        = puc_entry_next(cur_ent, PUC_TAG_MAX_W'(upd_tag), bus.upd_uc_i,
                                   PUC_CNT_MAX_W'(sat_ctr), puc_ctr_ones(CNT_W));
  end

  assign wr_valid  = wr_ent.valid;
  assign wr_tag    = wr_ent.tag[TAG_W-1:0];
  assign wr_ctr    = wr_ent.ctr[CNT_W-1:0];
  assign unused_wr = ^wr_ent;

  // Table storage has no reset; validity is only ever established by the clear walk.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (upd_accept) begin
      valid_q[upd_idx] <= wr_valid;
      tag_q[upd_idx]   <= wr_tag;
      ctr_q[upd_idx]   <= wr_ctr;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             byp;
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [CNT_W-1:0] e_ctr;
    logic             hit;

    assign r_idx   = bus.rd_addr_i[p*ADDR_W +: IDX_W];
    assign r_tag   = bus.rd_addr_i[p*ADDR_W+IDX_W +: TAG_W];
    // A same-index update is visible to the read in the cycle it is accepted.
    assign byp     = upd_accept && (r_idx == upd_idx);
    assign e_valid = byp ? wr_valid : valid_q[r_idx];
    assign e_tag   = byp ? wr_tag   : tag_q[r_idx];
    assign e_ctr   = byp ? wr_ctr   : ctr_q[r_idx];
    assign hit     = !busy && e_valid && (e_tag == r_tag);

    assign rd_hit[p] = hit;
    assign rd_uc[p]  = hit ? e_ctr[CNT_W-1] : DEFAULT_UC;
  end

  assign bus.rd_hit_o = rd_hit;
  assign bus.rd_uc_o  = rd_uc;
  assign bus.busy_o   = busy;

endmodule

// File: tb/tb_predictor_puc_tagged.sv
// Randomized and directed check of two predictor instances (CNT_W=2 and CNT_W=1)
// against an entry-table reference model kept in the bench.
module tb_predictor_puc_tagged;

  localparam int IW    = 5;
  localparam int TW    = 4;
  localparam int AW    = IW + TW;
  localparam int NP    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  predictor_puc_tagged_if #(.IDX_W(IW), .TAG_W(TW), .RD_PORTS(NP)) bus0 ();
  predictor_puc_tagged_if #(.IDX_W(IW), .TAG_W(TW), .RD_PORTS(NP)) bus1 ();

  predictor_puc_tagged #(
    .IDX_W(IW), .TAG_W(TW), .CNT_W(2), .RD_PORTS(NP), .DEFAULT_UC(1'b1)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  predictor_puc_tagged #(
    .IDX_W(IW), .TAG_W(TW), .CNT_W(1), .RD_PORTS(NP), .DEFAULT_UC(1'b1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance table of {valid, tag, counter value} plus remaining clear cycles.
  bit m_valid [2][DEPTH];
  int m_tag   [2][DEPTH];
  int m_ctr   [2][DEPTH];
  int cmax    [2] = '{3, 1};
  int clear_left = 0;
  bit known = 1'b0;
  int busy_seen = 0;

  bit cur_v;
  int cur_a;
  bit cur_uc;
  bit cur_fl;
  int cur_r [NP];

  logic last_hit [2][NP];
  logic last_uc  [2][NP];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int randAddr();
    return ($urandom_range(0, 3) << IW) | $urandom_range(0, 7);
  endfunction

  function automatic int trainedCtr(input int d, input int a, input bit uc);
    int i = a % DEPTH;
    int t = a / DEPTH;
    if (m_valid[d][i] && m_tag[d][i] == t) begin
      if (uc) return (m_ctr[d][i] + 1 > cmax[d]) ? cmax[d] : m_ctr[d][i] + 1;
      else    return (m_ctr[d][i] == 0) ? 0 : m_ctr[d][i] - 1;
    end
    return uc ? cmax[d] : 0;
  endfunction

  function automatic void expectRead(input int d, input int ra, output bit hit, output bit uc);
    int  i = ra % DEPTH;
    int  t = ra / DEPTH;
    bit  v;
    int  et;
    int  ec;
    bit  acc = (clear_left == 0) && cur_v && !cur_fl && rst_n;
    if (clear_left > 0) begin
      hit = 1'b0;
      uc  = 1'b1;
      return;
    end
    if (acc && (i == cur_a % DEPTH)) begin
      v  = 1'b1;
      et = cur_a / DEPTH;
      ec = trainedCtr(d, cur_a, cur_uc);
    end else begin
      v  = m_valid[d][i];
      et = m_tag[d][i];
      ec = m_ctr[d][i];
    end
    hit = v && (et == t);
    // Prediction is "uncache" when the counter sits in the upper half of its range.
    uc  = hit ? (ec > cmax[d] / 2) : 1'b1;
  endfunction

  task automatic applyStimulus(input bit v, input int a, input bit uc, input bit fl,
                               input int r0, input int r1);
    bit eh;
    bit eu;
    cur_v = v; cur_a = a; cur_uc = uc; cur_fl = fl;
    cur_r[0] = r0; cur_r[1] = r1;
    bus0.upd_valid_i = v;  bus1.upd_valid_i = v;
    bus0.upd_addr_i  = AW'(a); bus1.upd_addr_i = AW'(a);
    bus0.upd_uc_i    = uc; bus1.upd_uc_i = uc;
    bus0.flush_i     = fl; bus1.flush_i = fl;
    bus0.rd_addr_i   = {AW'(r1), AW'(r0)};
    bus1.rd_addr_i   = {AW'(r1), AW'(r0)};
    #2;
    for (int p = 0; p < NP; p++) begin
      last_hit[0][p] = bus0.rd_hit_o[p]; last_uc[0][p] = bus0.rd_uc_o[p];
      last_hit[1][p] = bus1.rd_hit_o[p]; last_uc[1][p] = bus1.rd_uc_o[p];
    end
    if (rst_n && bus0.busy_o === 1'b1) busy_seen++;
    if (known) begin
      checkOutput("busy d0", bus0.busy_o, (clear_left > 0));
      checkOutput("busy d1", bus1.busy_o, (clear_left > 0));
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          expectRead(d, cur_r[p], eh, eu);
          checkOutput($sformatf("hit d%0d p%0d a%0d", d, p, cur_r[p]), last_hit[d][p], eh);
          checkOutput($sformatf("uc d%0d p%0d a%0d", d, p, cur_r[p]), last_uc[d][p], eu);
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      known = 1'b1;
      clear_left = DEPTH;
      for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m_valid[d][i] = 1'b0;
    end else if (known) begin
      if (clear_left > 0) begin
        clear_left = fl ? DEPTH : clear_left - 1;
      end else if (fl) begin
        clear_left = DEPTH;
        for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m_valid[d][i] = 1'b0;
      end else if (v) begin
        for (int d = 0; d < 2; d++) begin
          m_ctr[d][a % DEPTH]   = trainedCtr(d, a, uc);
          m_valid[d][a % DEPTH] = 1'b1;
          m_tag[d][a % DEPTH]   = a / DEPTH;
        end
      end
    end
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, randAddr(), 1'b0, 1'b0, randAddr(), randAddr());
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (bus0.busy_o !== 1'b0 && n < 100) begin
      idleStep();
      n++;
    end
    checkOutput(tag, (n < 100), 1);
  endtask

  initial begin
    int a35;
    int a95;
    a35 = (3 << IW) | 5;
    a95 = (9 << IW) | 5;

    // T1: reset, then a 32-cycle walk and default predictions.
    rst_n = 1'b0;
    idleStep();
    rst_n = 1'b1;
    busy_seen = 0;
    waitIdle("reset walk bound");
    checkOutput("reset busy cycles", busy_seen, 32);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, a35, randAddr());
    checkOutput("post reset hit", last_hit[0][0], 0);
    checkOutput("post reset uc", last_uc[0][0], 1);

    // T2: allocate with same-cycle bypass.
    applyStimulus(1'b1, a35, 1'b0, 1'b0, a35, a95);
    checkOutput("alloc bypass hit", last_hit[0][0], 1);
    checkOutput("alloc bypass uc", last_uc[0][0], 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, a35, a95);
    checkOutput("alloc next hit", last_hit[0][0], 1);
    checkOutput("alloc next uc", last_uc[0][0], 0);

    // T3: hysteresis 00 -> 01 -> 10 -> 11 -> 11.
    applyStimulus(1'b1, a35, 1'b1, 1'b0, a35, a35);
    checkOutput("hyst ctr01 uc", last_uc[0][0], 0);
    checkOutput("hyst ctr01 plain", last_uc[1][0], 1);
    applyStimulus(1'b1, a35, 1'b1, 1'b0, a35, a35);
    checkOutput("hyst ctr10 uc", last_uc[0][0], 1);
    applyStimulus(1'b1, a35, 1'b1, 1'b0, a35, a35);
    applyStimulus(1'b1, a35, 1'b1, 1'b0, a35, a35);
    checkOutput("hyst sat uc", last_uc[0][0], 1);
    applyStimulus(1'b1, a35, 1'b0, 1'b0, a35, a35);
    checkOutput("hyst 11->10 uc", last_uc[0][0], 1);
    checkOutput("plain clear uc", last_uc[1][0], 0);

    // T4: alias replaces the entry; the old tag misses in the same cycle.
    applyStimulus(1'b1, a95, 1'b1, 1'b0, a35, a95);
    checkOutput("alias old hit", last_hit[0][0], 0);
    checkOutput("alias old uc", last_uc[0][0], 1);
    checkOutput("alias new hit", last_hit[0][1], 1);
    checkOutput("alias new uc", last_uc[0][1], 1);

    // T6: two ports on two different trained entries.
    applyStimulus(1'b1, (2 << IW) | 7, 1'b0, 1'b0, randAddr(), randAddr());
    applyStimulus(1'b1, (6 << IW) | 12, 1'b1, 1'b0, randAddr(), randAddr());
    applyStimulus(1'b0, 0, 1'b0, 1'b0, (2 << IW) | 7, (6 << IW) | 12);
    checkOutput("port0 hit", last_hit[0][0], 1);
    checkOutput("port0 uc", last_uc[0][0], 0);
    checkOutput("port1 hit", last_hit[0][1], 1);
    checkOutput("port1 uc", last_uc[0][1], 1);

    // T5: flush drops a simultaneous update and walks for 32 cycles.
    applyStimulus(1'b1, (1 << IW) | 1, 1'b0, 1'b1, (1 << IW) | 1, (2 << IW) | 7);
    busy_seen = 0;
    waitIdle("flush walk bound");
    checkOutput("flush busy cycles", busy_seen, 32);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, (1 << IW) | 1, (2 << IW) | 7);
    checkOutput("dropped upd hit", last_hit[0][0], 0);
    checkOutput("flushed entry hit", last_hit[0][1], 0);

    // Re-flush at ptr=10 extends the walk to 43 cycles.
    applyStimulus(1'b0, 0, 1'b0, 1'b1, randAddr(), randAddr());
    busy_seen = 0;
    repeat (10) idleStep();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, randAddr(), randAddr());
    waitIdle("reflush walk bound");
    checkOutput("reflush busy cycles", busy_seen, 43);

    // Reset at ptr=20 restarts the walk.
    applyStimulus(1'b0, 0, 1'b0, 1'b1, randAddr(), randAddr());
    repeat (20) idleStep();
    rst_n = 1'b0;
    idleStep();
    rst_n = 1'b1;
    busy_seen = 0;
    waitIdle("midwalk reset bound");
    checkOutput("midwalk reset busy cycles", busy_seen, 32);

    // Randomized traffic on a small address pool so hits, aliases and bypasses are frequent.
    for (int n = 0; n < 2000; n++) begin
      int a;
      int r0;
      int r1;
      a  = randAddr();
      r0 = ($urandom_range(0, 9) < 4) ? a : randAddr();
      r1 = ($urandom_range(0, 9) < 3) ? a : (($urandom_range(0, 9) < 3) ? r0 : randAddr());
      rst_n = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 149) == 0, r0, r1);
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
